ex_operand_stage: RTL and testbench
===================================

# ex_operand_stage

Registered EX-input operand stage for the RISC-V pipeline. It generalises the combinational ALU/FPU source selection to NSRC sources and NFWD forwarding ports, and latches the resolved operands into an EX-input register with a valid/ready handshake. Any source whose selected forwarding port is not yet valid, such as a load-use case, is held pending and captured later from the writeback broadcast. EX sees operands only when all of them are resolved.

## Interface
Parameters:
- XLEN, 32, operand width
- NSRC, 3, source operands per instruction (0=rs1, 1=rs2, 2=rs3/frs3)
- NFWD, 2, forwarding ports (port 0=MEM, 1=WB)
- SELW, $clog2(NFWD+1), per-source select width

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- id_valid  in  1  ID presents an instruction
- id_ready  out  1  stage can accept
- id_data  in  NSRC*XLEN  register-file values
- id_rs  in  NSRC*5  source register indices
- id_fwd_sel  in  NSRC*SELW  0=id_data, k=fwd port k-1, >NFWD=zero
- id_imm  in  XLEN  immediate
- id_imm_sel  in  1  immediate replaces source 1 on ex_ops
- fwd_data  in  NFWD*XLEN  forwarding values
- fwd_valid  in  NFWD  forwarding value is available this cycle
- wb_valid  in  1  writeback broadcast
- wb_rd  in  5  writeback register
- wb_data  in  XLEN  writeback value
- flush  in  1  kill held instruction
- ex_valid  out  1  operands complete
- ex_ready  in  1  EX consumes
- ex_ops  out  NSRC*XLEN  resolved operands, source 1 replaced by imm when imm_sel
- ex_store_data  out  XLEN  resolved source 1 before imm mux

## Operation
- Entry states: EMPTY, WAIT (at least one source pending), READY.
- Accept = id_valid & id_ready & !flush.
- id_ready = (state==EMPTY) | (state==READY & ex_ready). It is never asserted in WAIT.
- Per source at accept:
  - sel 0: take id_data, ready.
  - sel k≤NFWD with fwd_valid[k-1]=1: take fwd_data[k-1], ready.
  - sel k with fwd_valid[k-1]=0: pending, and store id_rs.
  - sel >NFWD: take 0, ready.
- Same-cycle wb_valid with wb_rd==id_rs on a would-be-pending source: capture wb_data at accept, so the source is ready.
- In WAIT, each pending source captures wb_data when wb_valid & wb_rd==stored rs. Multiple sources with the same rs capture together. A non-matching wb is ignored.
- Transitions:
  - EMPTY→READY or EMPTY→WAIT on accept.
  - WAIT→READY when the last pending source captures.
  - READY→EMPTY on ex_ready without accept.
  - READY→READY/WAIT on ex_ready with accept (back-to-back).
- flush: the next state is EMPTY, and all pending flags are cleared. flush beats accept, so a same-cycle incoming instruction is dropped.
- Immediate mux applies to the output only. Source 1 is still tracked and resolved, because stores need it as ex_store_data.
- ex_ops and ex_store_data are held stable while ex_valid & !ex_ready.

## Timing
- Reset values:
  - state: EMPTY
  - ex_valid: 0
  - ex_ops: 0
  - ex_store_data: 0
  - all pending flags: 0
- id_ready is 1 while in reset/EMPTY.
- Latency with all sources resolved at accept: ex_valid rises the next cycle.
- Latency with pending sources: ex_valid rises the cycle after the last capture.
- ex_valid = (state==READY). It is registered, with no combinational path from id_* or wb_*.
- Reset asserted mid-WAIT discards the entry immediately.
- Full throughput: 1 instruction/cycle while ex_ready=1 and no source is pending.

## Structure
- Shared package ex_operand_pkg:
  - state enum {EMPTY, WAIT, READY}
  - FWD_SEL_RF = 0 constant
  - REG_IDX_W = 5
- Sub-module operand_slot, instantiated NSRC times:
  - forwarding mux
  - value register
  - pending flag
  - stored rs
  - wb compare/capture
  - outputs: value and pending
- The top level holds the state FSM, the handshake, and the immediate mux.

## Test plan
- Reset, then accept sel=0 for all sources with id_data={A,B,C}. Expect ex_ops={A,B,C} one cycle later, ex_valid=1.
- Source 0 with sel=1, fwd_valid[0]=1, fwd_data=0x55. Expect ex_ops[0]=0x55. Repeat with sel=3 (>NFWD) and expect 0.
- Load-use: sel=1 with fwd_valid[0]=0 and rs=7. Expect WAIT, ex_valid=0, id_ready=0. Two cycles later wb_valid, rd=7, data=0xDEAD. Expect ex_valid the next cycle with ex_ops[0]=0xDEAD. Then send wb with rd=8 and check it is ignored.
- Store: imm_sel=1, imm=0x10, source 1 forwarded 0x99. Expect ex_ops[1]=0x10 and ex_store_data=0x99.
- Back-to-back with ex_ready low for 3 cycles. Expect outputs held and id_ready=0, then a single transfer per cycle.
- Flush in WAIT together with id_valid. Expect EMPTY, ex_valid stays 0, and a later wb with the matching rd has no effect.

Source files
------------

// File: rtl/ex_operand_pkg.sv
// ex_operand_pkg: shared types and constants for the EX operand stage.
package ex_operand_pkg;
  typedef enum logic [1:0] {EMPTY, WAIT, READY} state_t;
  localparam int FWD_SEL_RF = 0;
  localparam int REG_IDX_W = 5;
endpackage

// File: rtl/ex_operand_stage_slot.sv
// operand_slot: resolves one source operand from RF/forwarding and, when the
// chosen forwarding port is not yet valid, waits for it on the writeback broadcast.
module operand_slot
  import ex_operand_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NFWD = 2,
  parameter int SELW = $clog2(NFWD + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load,
  input  logic                   flush,
  input  logic [SELW-1:0]        sel,
  input  logic [XLEN-1:0]        rfData,
  input  logic [REG_IDX_W-1:0]   rs,
  input  logic [NFWD*XLEN-1:0]   fwdData,
  input  logic [NFWD-1:0]        fwdValid,
  input  logic                   wbValid,
  input  logic [REG_IDX_W-1:0]   wbRd,
  input  logic [XLEN-1:0]        wbData,
  output logic [XLEN-1:0]        value,
  output logic                   pendNext
);
  logic                 pending;
  logic [REG_IDX_W-1:0] rsQ;
  logic [XLEN-1:0]      muxVal;
  logic                 muxReady;
  logic                 hitNew;
  logic                 hitHeld;
  // selects beyond the last forwarding port resolve to zero
  always_comb begin
    muxVal   = '0;
    muxReady = 1'b1;
    if (int'(sel) == FWD_SEL_RF) muxVal = rfData;
    for (int k = 0; k < NFWD; k++)
      if (int'(sel) == k + 1) begin
        muxVal   = fwdData[k*XLEN +: XLEN];
        muxReady = fwdValid[k];
      end
  end
  assign hitNew   = wbValid && wbRd == rs;
  assign hitHeld  = wbValid && wbRd == rsQ;
  assign pendNext = flush ? 1'b0 : load ? !muxReady && !hitNew : pending && !hitHeld;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value   <= '0;
      pending <= 1'b0;
      rsQ     <= '0;
    end else begin
      pending <= pendNext;
      if (load) begin
        value <= (!muxReady && hitNew) ? wbData : muxVal;
        rsQ   <= rs;
      end else if (pending && hitHeld) begin
        value <= wbData;
      end
    end
  end
endmodule

// File: rtl/ex_operand_stage.sv
// ex_operand_stage: EX-input operand register with per-source forwarding,
// load-use wait on writeback, and a valid/ready handshake towards EX.
module ex_operand_stage
  import ex_operand_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NSRC = 3,
  parameter int NFWD = 2,
  parameter int SELW = $clog2(NFWD + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      id_valid,
  output logic                      id_ready,
  input  logic [NSRC*XLEN-1:0]      id_data,
  input  logic [NSRC*REG_IDX_W-1:0] id_rs,
  input  logic [NSRC*SELW-1:0]      id_fwd_sel,
  input  logic [XLEN-1:0]           id_imm,
  input  logic                      id_imm_sel,
  input  logic [NFWD*XLEN-1:0]      fwd_data,
  input  logic [NFWD-1:0]           fwd_valid,
  input  logic                      wb_valid,
  input  logic [REG_IDX_W-1:0]      wb_rd,
  input  logic [XLEN-1:0]           wb_data,
  input  logic                      flush,
  output logic                      ex_valid,
  input  logic                      ex_ready,
  output logic [NSRC*XLEN-1:0]      ex_ops,
  output logic [XLEN-1:0]           ex_store_data
);
  state_t                state;
  state_t                stateNext;
  logic                  accept;
  logic [NSRC-1:0]       pendNext;
  logic [NSRC*XLEN-1:0]  opsRaw;
  logic [XLEN-1:0]       immQ;
  logic                  immSelQ;
  assign id_ready = state == EMPTY || (state == READY && ex_ready);
  assign accept   = id_valid && id_ready && !flush;
  assign ex_valid = state == READY;
  for (genvar i = 0; i < NSRC; i++) begin : g_slot
    operand_slot #(.XLEN(XLEN), .NFWD(NFWD), .SELW(SELW)) u_slot (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (accept),
      .flush    (flush),
      .sel      (id_fwd_sel[i*SELW +: SELW]),
      .rfData   (id_data[i*XLEN +: XLEN]),
      .rs       (id_rs[i*REG_IDX_W +: REG_IDX_W]),
      .fwdData  (fwd_data),
      .fwdValid (fwd_valid),
      .wbValid  (wb_valid),
      .wbRd     (wb_rd),
      .wbData   (wb_data),
      .value    (opsRaw[i*XLEN +: XLEN]),
      .pendNext (pendNext[i])
    );
  end
  always_comb begin
    stateNext = flush                          ? EMPTY :
                accept                         ? (|pendNext ? WAIT : READY) :
                (state == WAIT && !(|pendNext)) ? READY :
                (state == READY && ex_ready)   ? EMPTY : state;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= EMPTY;
      immQ    <= '0;
      immSelQ <= 1'b0;
    end else begin
      state <= stateNext;
      if (accept) begin
        immQ    <= id_imm;
        immSelQ <= id_imm_sel;
      end
    end
  end
  // source 1 stays resolved underneath the immediate so stores can use it
  always_comb begin
    ex_ops = opsRaw;
    if (immSelQ) ex_ops[XLEN +: XLEN] = immQ;
  end
  assign ex_store_data = opsRaw[XLEN +: XLEN];
endmodule

// File: tb/tb_ex_operand_stage.sv
// tb_ex_operand_stage: directed checks of the EX operand stage.
module tb_ex_operand_stage;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic        id_ready;
  logic [95:0] id_data;
  logic [14:0] id_rs;
  logic [5:0]  id_fwd_sel;
  logic [31:0] id_imm;
  logic        id_imm_sel;
  logic [63:0] fwd_data;
  logic [1:0]  fwd_valid;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        flush;
  logic        ex_valid;
  logic        ex_ready;
  logic [95:0] ex_ops;
  logic [31:0] ex_store_data;
  int passed = 0;
  int total = 0;

  always #5 clk = ~clk;

  ex_operand_stage dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ready(id_ready),
    .id_data(id_data), .id_rs(id_rs), .id_fwd_sel(id_fwd_sel), .id_imm(id_imm),
    .id_imm_sel(id_imm_sel), .fwd_data(fwd_data), .fwd_valid(fwd_valid),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_ops(ex_ops), .ex_store_data(ex_store_data)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    id_valid = 0; id_data = '0; id_rs = '0; id_fwd_sel = '0; id_imm = '0; id_imm_sel = 0;
    fwd_data = '0; fwd_valid = '0; wb_valid = 0; wb_rd = '0; wb_data = '0; flush = 0; ex_ready = 1;
  endtask

  task automatic test_reset;
    idle();
    rst_n = 0;
    tick(); tick();
    total++; if (ex_valid !== 1'b0) $display("FAIL reset_ex_valid got %b exp 0", ex_valid); else passed++;
    total++; if (id_ready !== 1'b1) $display("FAIL reset_id_ready got %b exp 1", id_ready); else passed++;
    total++; if (ex_ops !== 96'h0) $display("FAIL reset_ex_ops got %h exp 0", ex_ops); else passed++;
    total++; if (ex_store_data !== 32'h0) $display("FAIL reset_store got %h exp 0", ex_store_data); else passed++;
    rst_n = 1;
    tick();
  endtask

  task automatic test_rf;
    id_valid = 1; id_data = {32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001};
    tick();
    idle();
    total++; if (ex_valid !== 1'b1) $display("FAIL rf_ex_valid got %b exp 1", ex_valid); else passed++;
    total++; if (ex_ops !== {32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001}) $display("FAIL rf_ops got %h exp cccc0003bbbb0002aaaa0001", ex_ops); else passed++;
    total++; if (ex_store_data !== 32'hBBBB_0002) $display("FAIL rf_store got %h exp bbbb0002", ex_store_data); else passed++;
    tick();
    total++; if (ex_valid !== 1'b0) $display("FAIL rf_drain got %b exp 0", ex_valid); else passed++;
  endtask

  task automatic test_fwd;
    id_valid = 1; id_data = {32'h3, 32'h2, 32'h1}; id_fwd_sel = {2'd0, 2'd0, 2'd1};
    fwd_valid = 2'b01; fwd_data = {32'h0, 32'h55};
    tick();
    idle();
    total++; if (ex_ops[31:0] !== 32'h55) $display("FAIL fwd_mem got %h exp 55", ex_ops[31:0]); else passed++;
    tick();
    id_valid = 1; id_data = {32'h3, 32'h2, 32'h1}; id_fwd_sel = {2'd0, 2'd2, 2'd3};
    fwd_valid = 2'b10; fwd_data = {32'h77, 32'h66};
    tick();
    idle();
    total++; if (ex_ops[31:0] !== 32'h0) $display("FAIL fwd_zero got %h exp 0", ex_ops[31:0]); else passed++;
    total++; if (ex_ops[63:32] !== 32'h77) $display("FAIL fwd_wb got %h exp 77", ex_ops[63:32]); else passed++;
    total++; if (ex_ops[95:64] !== 32'h3) $display("FAIL fwd_rf2 got %h exp 3", ex_ops[95:64]); else passed++;
    tick();
  endtask

  task automatic test_load_use;
    id_valid = 1; id_fwd_sel = {2'd0, 2'd0, 2'd1}; id_rs = {5'd0, 5'd0, 5'd7}; fwd_data = {32'h0, 32'h1111};
    tick();
    idle();
    total++; if (ex_valid !== 1'b0) $display("FAIL lu_wait_valid got %b exp 0", ex_valid); else passed++;
    total++; if (id_ready !== 1'b0) $display("FAIL lu_wait_ready got %b exp 0", id_ready); else passed++;
    tick();
    wb_valid = 1; wb_rd = 5'd7; wb_data = 32'hDEAD;
    tick();
    idle();
    total++; if (ex_valid !== 1'b1) $display("FAIL lu_done_valid got %b exp 1", ex_valid); else passed++;
    total++; if (ex_ops[31:0] !== 32'hDEAD) $display("FAIL lu_done_op got %h exp dead", ex_ops[31:0]); else passed++;
    tick();
    id_valid = 1; id_fwd_sel = {2'd2, 2'd0, 2'd2}; id_rs = {5'd9, 5'd0, 5'd9}; id_data = {32'h0, 32'h22, 32'h0};
    tick();
    idle();
    wb_valid = 1; wb_rd = 5'd8; wb_data = 32'h0BAD;
    tick();
    total++; if (ex_valid !== 1'b0) $display("FAIL lu_ignore_valid got %b exp 0", ex_valid); else passed++;
    total++; if (id_ready !== 1'b0) $display("FAIL lu_ignore_ready got %b exp 0", id_ready); else passed++;
    wb_rd = 5'd9; wb_data = 32'h1234;
    tick();
    idle();
    total++; if (ex_valid !== 1'b1) $display("FAIL lu_multi_valid got %b exp 1", ex_valid); else passed++;
    total++; if (ex_ops !== {32'h1234, 32'h22, 32'h1234}) $display("FAIL lu_multi_ops got %h exp 000012340000002200001234", ex_ops); else passed++;
    tick();
    id_valid = 1; id_fwd_sel = {2'd0, 2'd1, 2'd0}; id_rs = {5'd0, 5'd5, 5'd0};
    wb_valid = 1; wb_rd = 5'd5; wb_data = 32'h4242;
    tick();
    idle();
    total++; if (ex_valid !== 1'b1) $display("FAIL lu_same_cycle_valid got %b exp 1", ex_valid); else passed++;
    total++; if (ex_ops[63:32] !== 32'h4242) $display("FAIL lu_same_cycle_op got %h exp 4242", ex_ops[63:32]); else passed++;
    tick();
  endtask

  task automatic test_store;
    id_valid = 1; id_imm_sel = 1; id_imm = 32'h10; id_fwd_sel = {2'd0, 2'd1, 2'd0};
    fwd_valid = 2'b01; fwd_data = {32'h0, 32'h99}; id_data = {32'h3, 32'h2, 32'h1};
    tick();
    idle();
    total++; if (ex_ops[63:32] !== 32'h10) $display("FAIL store_imm got %h exp 10", ex_ops[63:32]); else passed++;
    total++; if (ex_store_data !== 32'h99) $display("FAIL store_data got %h exp 99", ex_store_data); else passed++;
    total++; if (ex_ops[31:0] !== 32'h1) $display("FAIL store_rs1 got %h exp 1", ex_ops[31:0]); else passed++;
    tick();
  endtask

  task automatic test_back_to_back;
    id_valid = 1; id_data = {32'h3, 32'h2, 32'h1}; ex_ready = 0;
    tick();
    id_data = {32'h6, 32'h5, 32'h4};
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (ex_ops !== {32'h3, 32'h2, 32'h1} || ex_valid !== 1'b1) $display("FAIL b2b_hold%0d got %h/%b exp 000000030000000200000001/1", i, ex_ops, ex_valid); else passed++;
      total++; if (id_ready !== 1'b0) $display("FAIL b2b_stall%0d got %b exp 0", i, id_ready); else passed++;
    end
    ex_ready = 1;
    #1;
    total++; if (id_ready !== 1'b1) $display("FAIL b2b_ready got %b exp 1", id_ready); else passed++;
    tick();
    id_data = {32'h9, 32'h8, 32'h7};
    total++; if (ex_ops !== {32'h6, 32'h5, 32'h4} || ex_valid !== 1'b1) $display("FAIL b2b_second got %h/%b exp 000000060000000500000004/1", ex_ops, ex_valid); else passed++;
    tick();
    idle();
    total++; if (ex_ops !== {32'h9, 32'h8, 32'h7} || ex_valid !== 1'b1) $display("FAIL b2b_third got %h/%b exp 000000090000000800000007/1", ex_ops, ex_valid); else passed++;
    tick();
    total++; if (ex_valid !== 1'b0) $display("FAIL b2b_drain got %b exp 0", ex_valid); else passed++;
  endtask

  task automatic test_flush;
    id_valid = 1; id_fwd_sel = {2'd0, 2'd0, 2'd1}; id_rs = {5'd0, 5'd0, 5'd12};
    tick();
    idle();
    flush = 1; id_valid = 1; id_data = {32'hA, 32'hB, 32'hC};
    tick();
    idle();
    total++; if (ex_valid !== 1'b0) $display("FAIL flush_valid got %b exp 0", ex_valid); else passed++;
    total++; if (id_ready !== 1'b1) $display("FAIL flush_empty got %b exp 1", id_ready); else passed++;
    wb_valid = 1; wb_rd = 5'd12; wb_data = 32'hF00;
    tick();
    idle();
    tick();
    total++; if (ex_valid !== 1'b0) $display("FAIL flush_wb_valid got %b exp 0", ex_valid); else passed++;
    total++; if (ex_ops[31:0] !== 32'h0) $display("FAIL flush_wb_op got %h exp 0", ex_ops[31:0]); else passed++;
    flush = 1; id_valid = 1; id_data = {32'hA, 32'hB, 32'hC};
    tick();
    idle();
    total++; if (ex_valid !== 1'b0 || ex_ops !== 96'h0) $display("FAIL flush_beats_accept got %b/%h exp 0/0", ex_valid, ex_ops); else passed++;
  endtask

  task automatic test_reset_in_wait;
    id_valid = 1; id_fwd_sel = {2'd0, 2'd0, 2'd1}; id_rs = {5'd0, 5'd0, 5'd3};
    tick();
    idle();
    total++; if (id_ready !== 1'b0) $display("FAIL rstw_wait got %b exp 0", id_ready); else passed++;
    #2 rst_n = 0;
    #1;
    total++; if (id_ready !== 1'b1 || ex_valid !== 1'b0) $display("FAIL rstw_async got %b/%b exp 1/0", id_ready, ex_valid); else passed++;
    rst_n = 1;
    tick();
    wb_valid = 1; wb_rd = 5'd3; wb_data = 32'hAB;
    tick();
    idle();
    total++; if (ex_valid !== 1'b0) $display("FAIL rstw_wb got %b exp 0", ex_valid); else passed++;
  endtask

  initial begin
    test_reset();
    test_rf();
    test_fwd();
    test_load_use();
    test_store();
    test_back_to_back();
    test_flush();
    test_reset_in_wait();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
